bldc_duty_ramp: RTL and testbench
=================================

Name: bldc_duty_ramp

Overview:
- Command conditioner that sits directly upstream of the no-encoder BLDC motor stage.
- Drives that stage's duty_cycle and en inputs, and consumes its has_error output.
- Slews the commanded duty toward a target at a bounded rate, so a step command cannot cause a current spike.
- On a motor error: forces the motor off, waits a holdoff, re-ramps from zero, and latches a lockout after repeated faults.

Parameters:
- DUTY_CYCLE_WIDTH, 9: width of duty command and output (matches motor stage, max 'h1FF).
- MAX_DUTY, 'h1FF: commands above this clamp to it.
- STEP, 4: duty increment/decrement per ramp tick.
- TICK_PERIOD, 256: clk cycles per ramp tick (>=1).
- FAULT_HOLDOFF, 18432: clk cycles motor held off after an error (~1 ms at 18.432 MHz).
- MAX_RETRIES, 3: faults tolerated before lockout.
- ERR_FILTER, 4: consecutive error cycles required when the filter feature is compiled in.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  one-cycle strobe; loads cmd_duty as the new target
- cmd_duty  in  DUTY_CYCLE_WIDTH  requested duty (unsigned)
- motor_error  in  1  has_error from the motor stage
- duty_out  out  DUTY_CYCLE_WIDTH  to motor duty_cycle
- motor_en  out  1  to motor en
- at_target  out  1  duty_out == target and state RUN
- faulted  out  1  high in FAULT or LOCKOUT
- locked_out  out  1  high in LOCKOUT
- retry_count  out  2  faults since last clear (saturating)

Behaviour:
- Reset values:
  - duty_out=0, motor_en=0, at_target=0, faulted=0, locked_out=0, retry_count=0.
  - target=0, tick counter=0, state=IDLE.
- Target load:
  - On cmd_valid, target <= min(cmd_duty, MAX_DUTY). Accepted in every state.
  - In LOCKOUT, only a cmd_duty==0 load has an effect (see LOCKOUT).
- Tick counter:
  - Free-runs 0..TICK_PERIOD-1 and wraps.
  - tick pulses for one cycle at wrap.
  - Reloaded to 0 on entry to RUN.
- States:
  - IDLE:
    - motor_en=0, duty_out=0.
    - Go to RUN when target!=0.
  - RUN:
    - motor_en=1.
    - On tick with duty_out<target: duty_out <= min(duty_out+STEP, target).
    - On tick with duty_out>target: duty_out <= max(duty_out-STEP, target).
    - Sums are computed at DUTY_CYCLE_WIDTH+1 bits, so there is no wrap past MAX_DUTY or below 0.
    - If target==0 and duty_out==0, go to IDLE.
  - FAULT:
    - Entered from RUN on a qualified error.
    - Same cycle as detection: duty_out<=0, motor_en<=0, retry_count increments (saturating).
    - Holdoff counter runs FAULT_HOLDOFF cycles, then go to IDLE, which re-ramps from 0 if target!=0.
    - If retry_count reaches MAX_RETRIES on entry, go to LOCKOUT instead.
  - LOCKOUT:
    - motor_en=0, duty_out=0, locked_out=1.
    - Leave to IDLE only on cmd_valid with cmd_duty==0, or on reset; this clears retry_count.
- motor_error is sampled only in RUN. The motor stage reports a disconnected hall while disabled, so errors are ignored in IDLE, FAULT and LOCKOUT.
- Retry clear: retry_count also clears after the state has remained in RUN with at_target=1 for 65536 consecutive clk cycles.
- Simultaneous events in one cycle, by priority:
  1. error in RUN: fault entry wins over a tick update.
  2. cmd_valid together with a tick: the tick steps toward the new target.
- Latency: cmd_valid to first duty_out change is at most TICK_PERIOD+1 cycles. Error to motor_en low is 1 cycle (registered).
- Reset mid-ramp or mid-holdoff returns every output to its reset value immediately (asynchronous).

Optional Feature:
- Macro: BLDC_DUTY_RAMP_ERR_FILTER_EN
- Defined: an error qualifies only after motor_error is high for ERR_FILTER consecutive RUN cycles. Any low cycle resets the filter count, and the count also resets on leaving RUN.
- Undefined: a single cycle of motor_error in RUN qualifies; error-to-motor_en-low stays 1 cycle.

Decomposition:
- Shared package bldc_pkg:
  - state encoding (IDLE, RUN, FAULT, LOCKOUT, 2 bits)
  - DUTY_CYCLE_WIDTH default
  - retry_count width
  - the 65536-cycle retry-clear constant
- Sub-module bldc_ramp_tick: parameterised prescaler with synchronous clear input, one-cycle tick output.

Test Plan:
- Ramp up: reset, cmd_duty=100 (TICK_PERIOD=4, STEP=4) -> duty_out 0,4,8..100 every 4 clks; at_target at 100; never exceeds 100.
- Ramp down and clamp: target 100 then cmd_duty='h1FF with MAX_DUTY='h180 -> rises to 'h180 exactly. Then cmd_duty=0 -> falls to 0 and enters IDLE with motor_en=0.
- Fault/retry: at duty 60, pulse motor_error 1 clk -> next cycle motor_en=0, duty_out=0, faulted=1, retry_count=1. After FAULT_HOLDOFF, re-ramps from 0 toward 60.
- Lockout: three faults -> locked_out=1. cmd_duty=50 is ignored. cmd_duty=0 clears to IDLE with retry_count=0.
- Filter (macro defined, ERR_FILTER=4): error high 3 clks then low -> no fault. High 4 clks -> fault on the 4th.
- Async reset mid-holdoff and mid-ramp -> all outputs return to 0 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC duty-ramp command conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default duty width, retry counter width,
// the at-target dwell length that clears the retry count, and a saturating
// increment for the retry counter.
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAULT   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    localparam int DUTY_W_DEF = 9;
    localparam int RETRY_W = 2;

    // Consecutive RUN + at_target cycles after which the retry count is forgiven.
    localparam int RETRY_CLEAR_CYCLES = 65536;
    localparam int STABLE_W = 17;

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bldc_ramp_tick.sv
// Ramp prescaler: free-running 0..TICK_PERIOD-1 counter, one-cycle tick at wrap.
// Latency: tick_o is combinational from the count register; clr_i takes effect next cycle.
// Backpressure: none; free-running.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clr_i       - synchronous clear, count restarts at 0 on the next edge
//   tick_o      - high for the single cycle in which the count is TICK_PERIOD-1
module bldc_ramp_tick #(
    parameter int TICK_PERIOD = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bldc_duty_ramp.sv
// Slew-limited duty command conditioner with fault holdoff, retry and lockout for a BLDC stage.
// Latency: cmd_valid to first duty_out change <= TICK_PERIOD+1 cycles; error to motor_en low 1 cycle.
// Backpressure: none; cmd_valid is a strobe, a newer command simply replaces the target.
//
// Optional build macro: BLDC_DUTY_RAMP_ERR_FILTER_EN -- when defined, motor_error must stay
// high for ERR_FILTER consecutive RUN cycles before it counts as a fault.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   cmd_valid    - strobe loading cmd_duty (clamped to MAX_DUTY) as the target
//   cmd_duty     - requested duty
//   motor_error  - has_error from the motor stage, only honoured in RUN
//   duty_out     - duty_cycle to the motor stage
//   motor_en     - en to the motor stage (high only in RUN)
//   at_target    - RUN and duty_out equals target
//   faulted      - FAULT or LOCKOUT
//   locked_out   - LOCKOUT
//   retry_count  - faults since last clear, saturating
module bldc_duty_ramp
    import bldc_pkg::*;
#(
    parameter int DUTY_CYCLE_WIDTH = DUTY_W_DEF,
    parameter int MAX_DUTY         = 'h1FF,
    parameter int STEP             = 4,
    parameter int TICK_PERIOD      = 256,
    parameter int FAULT_HOLDOFF    = 18432,
    parameter int MAX_RETRIES      = 3,
    parameter int ERR_FILTER       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    input  logic [DUTY_CYCLE_WIDTH-1:0] cmd_duty,
    input  logic                        motor_error,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_out,
    output logic                        motor_en,
    output logic                        at_target,
    output logic                        faulted,
    output logic                        locked_out,
    output logic [RETRY_W-1:0]          retry_count
);

    localparam int W = DUTY_CYCLE_WIDTH;
    localparam logic [W-1:0] MAX_D = W'(MAX_DUTY);
    localparam logic [W:0] STEP_X = (W + 1)'(STEP);

    localparam int HW = $clog2(FAULT_HOLDOFF + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(FAULT_HOLDOFF - 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(RETRY_CLEAR_CYCLES - 1);

    // The filter counter is sized for the configured filter length in both builds;
    // without the filter the qualifying length collapses to a single cycle.
    localparam int FILT_CFG = (ERR_FILTER < 1) ? 1 : ERR_FILTER;
    localparam int FW = $clog2(FILT_CFG + 1);
`ifdef BLDC_DUTY_RAMP_ERR_FILTER_EN
    localparam int FILT_LEN = FILT_CFG;
`else
    localparam int FILT_LEN = 1;
`endif
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

    state_e               state_q, state_d;
    logic [W-1:0]         duty_q, duty_d;
    logic [W-1:0]         target_q, target_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [STABLE_W-1:0]  stable_q, stable_d;
    logic [FW-1:0]        filt_q, filt_d;

    logic                 tick;
    logic                 tick_clr;
    logic                 err_qual;
    logic [W-1:0]         cmd_clamped;
    logic [W-1:0]         ramp_next;
    logic [RETRY_W-1:0]   retry_inc;
    logic [W:0]           duty_x, tgt_x, up_x;

    bldc_ramp_tick #(
        .TICK_PERIOD (TICK_PERIOD)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    assign cmd_clamped = (cmd_duty > MAX_D) ? MAX_D : cmd_duty;
    assign retry_inc   = retry_sat_inc(retry_q);
    assign tick_clr    = (state_q != ST_RUN) && (state_d == ST_RUN);

    // Consecutive-error filter; any low cycle or any cycle outside RUN restarts it.
    always_comb begin
        filt_d   = '0;
        err_qual = 1'b0;
        if ((state_q == ST_RUN) && motor_error) begin
            if (filt_q == FILT_LAST) begin
                err_qual = 1'b1;
            end else begin
                filt_d = filt_q + 1'b1;
            end
        end
    end

    // One ramp step toward the target being loaded this cycle, so a command that
    // coincides with a tick is stepped toward immediately. Math is one bit wider
    // than the duty so neither direction can wrap.
    always_comb begin
        duty_x    = {1'b0, duty_q};
        tgt_x     = {1'b0, target_d};
        up_x      = duty_x + STEP_X;
        ramp_next = duty_q;
        if (duty_x < tgt_x) begin
            ramp_next = (up_x > tgt_x) ? target_d : up_x[W-1:0];
        end else if (duty_x > tgt_x) begin
            ramp_next = (duty_x < tgt_x + STEP_X) ? target_d : duty_q - STEP_X[W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        retry_d  = retry_q;
        hold_d   = hold_q;
        stable_d = '0;

        // In LOCKOUT only a zero command is honoured; it is also the unlock request.
        if (cmd_valid) begin
            if (state_q != ST_LOCKOUT) begin
                target_d = cmd_clamped;
            end else if (cmd_duty == '0) begin
                target_d = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                duty_d = '0;
                if (target_q != '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (err_qual) begin
                    // Fault entry takes priority over any ramp step this cycle.
                    duty_d  = '0;
                    retry_d = retry_inc;
                    hold_d  = '0;
                    state_d = (int'(retry_inc) >= MAX_RETRIES) ? ST_LOCKOUT : ST_FAULT;
                end else if ((target_q == '0) && (duty_q == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    if (tick) begin
                        duty_d = ramp_next;
                    end
                    if (at_target) begin
                        if (stable_q == STABLE_LAST) begin
                            retry_d = '0;
                        end else begin
                            stable_d = stable_q + 1'b1;
                        end
                    end
                end
            end
            ST_FAULT: begin
                duty_d = '0;
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                duty_d = '0;
                if (cmd_valid && (cmd_duty == '0)) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            retry_q  <= '0;
            hold_q   <= '0;
            stable_q <= '0;
            filt_q   <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            hold_q   <= hold_d;
            stable_q <= stable_d;
            filt_q   <= filt_d;
        end
    end

    assign duty_out    = duty_q;
    assign motor_en    = (state_q == ST_RUN);
    assign at_target   = (state_q == ST_RUN) && (duty_q == target_q);
    assign faulted     = (state_q == ST_FAULT) || (state_q == ST_LOCKOUT);
    assign locked_out  = (state_q == ST_LOCKOUT);
    assign retry_count = retry_q;

endmodule

// File: tb/tb_bldc_duty_ramp.sv
// Directed bench for bldc_duty_ramp: TICK_PERIOD=4, STEP=4, MAX_DUTY='h180, FAULT_HOLDOFF=20.
module tb_bldc_duty_ramp;

`ifdef BLDC_DUTY_RAMP_ERR_FILTER_EN
    localparam int ELEN = 4;
`else
    localparam int ELEN = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [8:0] cmd_duty = '0;
    logic       motor_error = 1'b0;
    logic [8:0] duty_out;
    logic       motor_en;
    logic       at_target;
    logic       faulted;
    logic       locked_out;
    logic [1:0] retry_count;

    int total = 0;
    int bad = 0;

    bldc_duty_ramp #(
        .DUTY_CYCLE_WIDTH (9),
        .MAX_DUTY         ('h180),
        .STEP             (4),
        .TICK_PERIOD      (4),
        .FAULT_HOLDOFF    (20),
        .MAX_RETRIES      (3),
        .ERR_FILTER       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_duty    (cmd_duty),
        .motor_error (motor_error),
        .duty_out    (duty_out),
        .motor_en    (motor_en),
        .at_target   (at_target),
        .faulted     (faulted),
        .locked_out  (locked_out),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       cv;
        int       cd;
        int       elen;
        int       n;
        int       d;
        int       en;
        int       at;
        int       flt;
        int       lk;
        int       r;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input bit cv, input int cd, input int elen, input int n,
                        input int d, input int en, input int at, input int flt,
                        input int lk, input int r);
        vec_t v;
        v.cv = cv; v.cd = cd; v.elen = elen; v.n = n;
        v.d = d; v.en = en; v.at = at; v.flt = flt; v.lk = lk; v.r = r;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0d want=%0d", nm, idx, got, want);
        end
    endtask

    task automatic chk_all(input int idx, input int d, input int en, input int at,
                           input int flt, input int lk, input int r);
        chk("duty_out", idx, int'(duty_out), d);
        chk("motor_en", idx, int'(motor_en), en);
        chk("at_target", idx, int'(at_target), at);
        chk("faulted", idx, int'(faulted), flt);
        chk("locked_out", idx, int'(locked_out), lk);
        chk("retry_count", idx, int'(retry_count), r);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input int d);
        cmd_valid = 1'b1;
        cmd_duty = 9'(d);
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Ramp up to 100.
        addv(1, 100, 0, 1,    0, 0, 0, 0, 0, 0);
        addv(0, 0,   0, 1,    0, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 3,    0, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 1,    4, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 4,    8, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 88,  96, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 4,  100, 1, 1, 0, 0, 0);
        addv(0, 0,   0, 8,  100, 1, 1, 0, 0, 0);
        // 'h1FF clamps to 'h180 = 384.
        addv(1, 'h1FF, 0, 1, 100, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 3,  104, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 276, 380, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 4,  384, 1, 1, 0, 0, 0);
        addv(0, 0,   0, 8,  384, 1, 1, 0, 0, 0);
        // Ramp down to zero then drop to IDLE.
        addv(1, 0,   0, 1,  384, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 3,  380, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 376,  4, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 4,    0, 1, 1, 0, 0, 0);
        addv(0, 0,   0, 1,    0, 0, 0, 0, 0, 0);
        addv(0, 0,   0, 3,    0, 0, 0, 0, 0, 0);
        // Error while idle is ignored.
        addv(0, 0, ELEN, ELEN, 0, 0, 0, 0, 0, 0);
        // Fault at duty 60, holdoff, re-ramp.
        addv(1, 60,  0, 1,    0, 0, 0, 0, 0, 0);
        addv(0, 0,   0, 1,    0, 1, 0, 0, 0, 0);
        addv(0, 0,   0, 60,  60, 1, 1, 0, 0, 0);
        addv(0, 0, ELEN, ELEN, 0, 0, 0, 1, 0, 1);
        addv(0, 0,   0, 19,   0, 0, 0, 1, 0, 1);
        addv(0, 0,   0, 1,    0, 0, 0, 0, 0, 1);
        addv(0, 0,   0, 1,    0, 1, 0, 0, 0, 1);
        addv(0, 0,   0, 60,  60, 1, 1, 0, 0, 1);
        // Second and third faults lead to lockout.
        addv(0, 0, ELEN, ELEN, 0, 0, 0, 1, 0, 2);
        addv(0, 0,   0, 20,   0, 0, 0, 0, 0, 2);
        addv(0, 0,   0, 1,    0, 1, 0, 0, 0, 2);
        addv(0, 0, ELEN, ELEN, 0, 0, 0, 1, 1, 3);
        addv(1, 50,  0, 1,    0, 0, 0, 1, 1, 3);
        addv(0, 0,   0, 5,    0, 0, 0, 1, 1, 3);
        addv(1, 0,   0, 1,    0, 0, 0, 0, 0, 0);
        addv(0, 0,   0, 3,    0, 0, 0, 0, 0, 0);

        // Async reset at time 2, outputs checked before any clock edge.
        #2 reset = 1'b1;
        #1 chk_all(-1, 0, 0, 0, 0, 0, 0);
        step(2);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            cmd_valid = v.cv;
            cmd_duty = 9'(v.cd);
            motor_error = (v.elen != 0);
            for (int k = 1; k <= v.n; k++) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                if (k >= v.elen) motor_error = 1'b0;
            end
            chk_all(i, v.d, v.en, v.at, v.flt, v.lk, v.r);
        end

        // Retry count forgiven after 65536 consecutive at-target RUN cycles.
        cmd(4);
        step(1);
        motor_error = 1'b1;
        step(ELEN);
        motor_error = 1'b0;
        chk("clr_fault", 100, int'(retry_count), 1);
        step(20);
        chk("clr_idle", 101, int'(faulted), 0);
        step(1);
        step(4);
        chk("clr_at", 102, int'(at_target), 1);
        chk("clr_duty", 102, int'(duty_out), 4);
        step(65535);
        chk("clr_before", 103, int'(retry_count), 1);
        step(1);
        chk("clr_after", 104, int'(retry_count), 0);

        // Async reset mid-ramp.
        cmd(100);
        step(19);
        chk("mid_ramp_duty", 110, int'(duty_out), 24);
        #2 reset = 1'b1;
        #1 chk_all(111, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Async reset mid-holdoff.
        cmd(60);
        step(1);
        motor_error = 1'b1;
        step(ELEN);
        motor_error = 1'b0;
        step(5);
        chk("holdoff_flt", 120, int'(faulted), 1);
        #2 reset = 1'b1;
        #1 chk_all(121, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef BLDC_DUTY_RAMP_ERR_FILTER_EN
        // Three error cycles are filtered out; four qualify on the fourth.
        cmd(60);
        step(1);
        step(60);
        chk("filt_at", 130, int'(at_target), 1);
        motor_error = 1'b1;
        step(3);
        motor_error = 1'b0;
        step(1);
        chk("filt_3", 131, int'(faulted), 0);
        motor_error = 1'b1;
        step(3);
        chk("filt_4a", 132, int'(faulted), 0);
        step(1);
        motor_error = 1'b0;
        chk("filt_4b", 133, int'(faulted), 1);
        chk("filt_4r", 133, int'(retry_count), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
